// File: rtl/lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit: op codes, FSM states,
// exception causes and op-classification helpers.
package lsu_pkg;

   localparam logic [3:0] LSU_NOP = 4'h0;
   localparam logic [3:0] LSU_LB  = 4'h1;
   localparam logic [3:0] LSU_LBU = 4'h2;
   localparam logic [3:0] LSU_LH  = 4'h3;
   localparam logic [3:0] LSU_LHU = 4'h4;
   localparam logic [3:0] LSU_LW  = 4'h5;
   localparam logic [3:0] LSU_SB  = 4'h6;
   localparam logic [3:0] LSU_SH  = 4'h7;
   localparam logic [3:0] LSU_SW  = 4'h8;
   localparam logic [3:0] LSU_LL  = 4'h9;
   localparam logic [3:0] LSU_SC  = 4'hA;

   localparam logic [4:0] CAUSE_ADEL   = 5'd4;
   localparam logic [4:0] CAUSE_ADES   = 5'd5;
   localparam logic [4:0] CAUSE_BUSERR = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   function automatic logic is_mem_op(input logic [3:0] op);
      return op inside {LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW,
                        LSU_SB, LSU_SH, LSU_SW, LSU_LL, LSU_SC};
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op inside {LSU_SB, LSU_SH, LSU_SW, LSU_SC};
   endfunction

   // Halfwords need bit 0 clear; word-sized ops need both low bits clear.
   function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
      logic m;
      m = 1'b0;
      if (op inside {LSU_LH, LSU_LHU, LSU_SH})
         m = a[0];
      else if (op inside {LSU_LW, LSU_SW, LSU_LL, LSU_SC})
         m = (a != 2'b00);
      return m;
   endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte-lane steering for a big-endian bus of DW bits: lane enables, store data
// replication and load data extraction with sign/zero extension.
module lsu_lane
   import lsu_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic [3:0]               op_i,
   input  logic [$clog2(DW/8)-1:0]  off_i,
   input  logic [31:0]              wdata_i,
   input  logic [DW-1:0]            rdata_i,
   output logic [DW/8-1:0]          sel_o,
   output logic [DW-1:0]            wdata_o,
   output logic [31:0]              ldata_o
);

   localparam int unsigned SW = DW / 8;

   logic [31:0] o_c, ho_c, wo_c;
   logic [7:0]  byte_c;
   logic [15:0] half_c;
   logic [31:0] word_c;

   // Byte offset 0 sits in the most significant lane, so shift down from the top.
   always_comb begin
      o_c    = 32'(off_i);
      ho_c   = o_c & 32'hFFFF_FFFE;
      wo_c   = o_c & 32'hFFFF_FFFC;
      byte_c = 8'(rdata_i >> (8 * (SW - 1 - o_c)));
      half_c = 16'(rdata_i >> (8 * (SW - 2 - ho_c)));
      word_c = 32'(rdata_i >> (8 * (SW - 4 - wo_c)));
   end

   always_comb begin
      sel_o   = '0;
      wdata_o = '0;
      ldata_o = '0;
      case (op_i)
         LSU_LB: begin
            sel_o   = SW'(1) << (SW - 1 - o_c);
            ldata_o = {{24{byte_c[7]}}, byte_c};
         end
         LSU_LBU: begin
            sel_o   = SW'(1) << (SW - 1 - o_c);
            ldata_o = {24'h0, byte_c};
         end
         LSU_LH: begin
            sel_o   = SW'(2'b11) << (SW - 2 - ho_c);
            ldata_o = {{16{half_c[15]}}, half_c};
         end
         LSU_LHU: begin
            sel_o   = SW'(2'b11) << (SW - 2 - ho_c);
            ldata_o = {16'h0, half_c};
         end
         LSU_LW, LSU_LL: begin
            sel_o   = SW'(4'hF) << (SW - 4 - wo_c);
            ldata_o = word_c;
         end
         LSU_SB: begin
            sel_o   = SW'(1) << (SW - 1 - o_c);
            wdata_o = {SW{wdata_i[7:0]}};
         end
         LSU_SH: begin
            sel_o   = SW'(2'b11) << (SW - 2 - ho_c);
            wdata_o = {(SW / 2){wdata_i[15:0]}};
         end
         LSU_SW, LSU_SC: begin
            sel_o   = SW'(4'hF) << (SW - 4 - wo_c);
            wdata_o = {(DW / 32){wdata_i}};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle load/store unit: one req/ack bus transaction per memory op, with
// pipeline stall, LL/SC link bit, alignment checks, bus errors and timeout.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid_i,
   input  logic [3:0]        op_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              flush_i,
   input  logic              llclr_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [AW-1:0]     bus_addr_o,
   output logic [DW/8-1:0]   bus_sel_o,
   output logic [DW-1:0]     bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [DW-1:0]     bus_rdata_i,
   input  logic              bus_err_i,
   output logic              stall_req_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              exc_adel_o,
   output logic              exc_ades_o,
   output logic              exc_buserr_o,
   output logic              llbit_o
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned OW = $clog2(SW);
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   lsu_state_e     state_q;
   logic [3:0]     op_q;
   logic [OW-1:0]  off_q;
   logic [CW-1:0]  cnt_q;
   logic           flushed_q;
   logic           llbit_q;
   logic           bus_req_q;
   logic           bus_we_q;
   logic [AW-1:0]  bus_addr_q;
   logic [SW-1:0]  bus_sel_q;
   logic [DW-1:0]  bus_wdata_q;
   logic           done_q;
   logic [31:0]    rdata_q;
   logic           adel_q;
   logic           ades_q;
   logic           buserr_q;

   logic           accept_c;
   logic           misalign_c;
   logic           timeout_c;
   logic           kill_c;
   logic [3:0]     lane_op_c;
   logic [OW-1:0]  lane_off_c;
   logic [SW-1:0]  lane_sel_c;
   logic [DW-1:0]  lane_wdata_c;
   logic [31:0]    lane_ldata_c;

   always_comb begin
      accept_c   = (state_q == ST_IDLE) && op_valid_i && is_mem_op(op_i) && !flush_i;
      misalign_c = misaligned(op_i, addr_i[1:0]);
      timeout_c  = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);
      kill_c     = flushed_q || flush_i;
      // Lanes follow the live op while accepting and the captured op while on the bus.
      lane_op_c  = (state_q == ST_BUS) ? op_q  : op_i;
      lane_off_c = (state_q == ST_BUS) ? off_q : addr_i[OW-1:0];
   end

   lsu_lane #(.DW(DW)) u_lane (
      .op_i    (lane_op_c),
      .off_i   (lane_off_c),
      .wdata_i (wdata_i),
      .rdata_i (bus_rdata_i),
      .sel_o   (lane_sel_c),
      .wdata_o (lane_wdata_c),
      .ldata_o (lane_ldata_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= LSU_NOP;
         off_q       <= '0;
         cnt_q       <= '0;
         flushed_q   <= 1'b0;
         llbit_q     <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= '0;
         bus_wdata_q <= '0;
         done_q      <= 1'b0;
         rdata_q     <= '0;
         adel_q      <= 1'b0;
         ades_q      <= 1'b0;
         buserr_q    <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         adel_q   <= 1'b0;
         ades_q   <= 1'b0;
         buserr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  op_q      <= op_i;
                  off_q     <= addr_i[OW-1:0];
                  cnt_q     <= '0;
                  flushed_q <= 1'b0;
                  if (misalign_c) begin
                     state_q <= ST_DONE;
                     adel_q  <= !is_store(op_i);
                     ades_q  <= is_store(op_i);
                  end else if (op_i == LSU_SC && !llbit_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     rdata_q <= 32'd0;
                  end else begin
                     state_q     <= ST_BUS;
                     bus_req_q   <= 1'b1;
                     bus_we_q    <= is_store(op_i);
                     bus_addr_q  <= {addr_i[AW-1:OW], OW'(0)};
                     bus_sel_q   <= lane_sel_c;
                     bus_wdata_q <= lane_wdata_c;
                  end
               end
            end
            ST_BUS: begin
               cnt_q <= cnt_q + CW'(1);
               if (flush_i)
                  flushed_q <= 1'b1;
               // A flushed op still finishes on the bus but reports nothing.
               if (bus_err_i || timeout_c) begin
                  state_q   <= ST_DONE;
                  bus_req_q <= 1'b0;
                  buserr_q  <= !kill_c;
               end else if (bus_ack_i) begin
                  state_q   <= ST_DONE;
                  bus_req_q <= 1'b0;
                  if (!kill_c) begin
                     done_q <= 1'b1;
                     if (op_q == LSU_SC)
                        rdata_q <= 32'd1;
                     else if (!is_store(op_q))
                        rdata_q <= lane_ldata_c;
                     if (op_q == LSU_LL)
                        llbit_q <= 1'b1;
                     else if (op_q == LSU_SC)
                        llbit_q <= 1'b0;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         if (llclr_i)
            llbit_q <= 1'b0;
      end
   end

   assign bus_req_o    = bus_req_q;
   assign bus_we_o     = bus_we_q;
   assign bus_addr_o   = bus_addr_q;
   assign bus_sel_o    = bus_sel_q;
   assign bus_wdata_o  = bus_wdata_q;
   assign stall_req_o  = !rst && (accept_c || (state_q == ST_BUS));
   assign done_o       = done_q;
   assign rdata_o      = rdata_q;
   assign exc_adel_o   = adel_q;
   assign exc_ades_o   = ades_q;
   assign exc_buserr_o = buserr_q;
   assign llbit_o      = llbit_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a DW=32 and a DW=64 instance, both with TIMEOUT=8.
module tb_mem_lsu;
   import lsu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ov32, ov64, flush, llclr;
   logic [3:0]  op;
   logic [31:0] addr, wdata;
   logic        ack32, err32, ack64, err64;
   logic [31:0] rdi32;
   logic [63:0] rdi64;

   logic        req32, we32, stall32, done32, adel32, ades32, be32, ll32;
   logic [31:0] ba32, bw32, rd32;
   logic [3:0]  sel32;
   logic        req64, we64, stall64, done64, adel64, ades64, be64, ll64;
   logic [31:0] ba64, rd64;
   logic [63:0] bw64;
   logic [7:0]  sel64;

   int n_vec = 0;
   int n_err = 0;

   mem_lsu #(.AW(32), .DW(32), .TIMEOUT(8)) u32 (
      .clk(clk), .rst(rst), .op_valid_i(ov32), .op_i(op), .addr_i(addr), .wdata_i(wdata),
      .flush_i(flush), .llclr_i(llclr), .bus_req_o(req32), .bus_we_o(we32), .bus_addr_o(ba32),
      .bus_sel_o(sel32), .bus_wdata_o(bw32), .bus_ack_i(ack32), .bus_rdata_i(rdi32),
      .bus_err_i(err32), .stall_req_o(stall32), .done_o(done32), .rdata_o(rd32),
      .exc_adel_o(adel32), .exc_ades_o(ades32), .exc_buserr_o(be32), .llbit_o(ll32));

   mem_lsu #(.AW(32), .DW(64), .TIMEOUT(8)) u64 (
      .clk(clk), .rst(rst), .op_valid_i(ov64), .op_i(op), .addr_i(addr), .wdata_i(wdata),
      .flush_i(flush), .llclr_i(llclr), .bus_req_o(req64), .bus_we_o(we64), .bus_addr_o(ba64),
      .bus_sel_o(sel64), .bus_wdata_o(bw64), .bus_ack_i(ack64), .bus_rdata_i(rdi64),
      .bus_err_i(err64), .stall_req_o(stall64), .done_o(done64), .rdata_o(rd64),
      .exc_adel_o(adel64), .exc_ades_o(ades64), .exc_buserr_o(be64), .llbit_o(ll64));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_vec++; if ({req32, stall32, done32, rd32, adel32, ades32, be32, ll32} !== '0) begin n_err++; $display("FAIL reset_ctrl32 got=%h exp=0", {req32, stall32, done32, rd32, adel32, ades32, be32, ll32}); end
      n_vec++; if ({we32, ba32, sel32, bw32} !== '0) begin n_err++; $display("FAIL reset_bus32 got=%h exp=0", {we32, ba32, sel32, bw32}); end
      n_vec++; if ({req64, stall64, done64, rd64, ll64} !== '0) begin n_err++; $display("FAIL reset_ctrl64 got=%h exp=0", {req64, stall64, done64, rd64, ll64}); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_load_byte();
      logic [3:0]  ops [2];
      logic [31:0] exp [2];
      ops[0] = LSU_LB;  exp[0] = 32'hFFFF_FF99;
      ops[1] = LSU_LBU; exp[1] = 32'h0000_0099;
      for (int i = 0; i < 2; i++) begin
         tick(); ov32 = 1'b1; op = ops[i]; addr = 32'h101;
         @(negedge clk);
         n_vec++; if (stall32 !== 1'b1) begin n_err++; $display("FAIL lb%0d_stall_acc got=%b exp=1", i, stall32); end
         n_vec++; if (req32 !== 1'b0) begin n_err++; $display("FAIL lb%0d_req_acc got=%b exp=0", i, req32); end
         tick(); ack32 = 1'b1; rdi32 = 32'h8899_AABB;
         @(negedge clk);
         n_vec++; if (req32 !== 1'b1) begin n_err++; $display("FAIL lb%0d_req got=%b exp=1", i, req32); end
         n_vec++; if (sel32 !== 4'b0100) begin n_err++; $display("FAIL lb%0d_sel got=%b exp=0100", i, sel32); end
         n_vec++; if (ba32 !== 32'h100) begin n_err++; $display("FAIL lb%0d_addr got=%h exp=100", i, ba32); end
         tick(); ack32 = 1'b0; ov32 = 1'b0;
         @(negedge clk);
         n_vec++; if (done32 !== 1'b1) begin n_err++; $display("FAIL lb%0d_done got=%b exp=1", i, done32); end
         n_vec++; if (rd32 !== exp[i]) begin n_err++; $display("FAIL lb%0d_rdata got=%h exp=%h", i, rd32, exp[i]); end
         n_vec++; if (stall32 !== 1'b0) begin n_err++; $display("FAIL lb%0d_stall_done got=%b exp=0", i, stall32); end
      end
   endtask

   task automatic test_store_half();
      tick();
      @(negedge clk);
      n_vec++; if (stall32 !== 1'b0) begin n_err++; $display("FAIL sh_stall_idle got=%b exp=0", stall32); end
      tick(); ov32 = 1'b1; op = LSU_SH; addr = 32'h102; wdata = 32'h1234_ABCD;
      @(negedge clk);
      n_vec++; if (stall32 !== 1'b1) begin n_err++; $display("FAIL sh_stall_acc got=%b exp=1", stall32); end
      tick(); ack32 = 1'b1;
      @(negedge clk);
      n_vec++; if (bw32 !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata got=%h exp=abcdabcd", bw32); end
      n_vec++; if (sel32 !== 4'b0011) begin n_err++; $display("FAIL sh_sel got=%b exp=0011", sel32); end
      n_vec++; if ({req32, we32, stall32} !== 3'b111) begin n_err++; $display("FAIL sh_req_we_stall got=%b exp=111", {req32, we32, stall32}); end
      tick(); ack32 = 1'b0; ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if ({done32, stall32} !== 2'b10) begin n_err++; $display("FAIL sh_done_stall got=%b exp=10", {done32, stall32}); end
   endtask

   task automatic test_ll_sc_misaligned();
      tick(); ov32 = 1'b1; op = LSU_LL; addr = 32'h200;
      tick(); ack32 = 1'b1; rdi32 = 32'hDEAD_BEEF;
      @(negedge clk);
      n_vec++; if (ll32 !== 1'b0) begin n_err++; $display("FAIL ll_bit_early got=%b exp=0", ll32); end
      tick(); ack32 = 1'b0; ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if (rd32 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ll_rdata got=%h exp=deadbeef", rd32); end
      n_vec++; if (ll32 !== 1'b1) begin n_err++; $display("FAIL ll_bit_set got=%b exp=1", ll32); end
      // Misaligned word load while the link bit is set.
      tick(); ov32 = 1'b1; op = LSU_LW; addr = 32'h103;
      @(negedge clk);
      n_vec++; if ({stall32, req32} !== 2'b10) begin n_err++; $display("FAIL adel_acc got=%b exp=10", {stall32, req32}); end
      tick(); ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if (adel32 !== 1'b1) begin n_err++; $display("FAIL adel_pulse got=%b exp=1", adel32); end
      n_vec++; if ({done32, req32, ades32, ll32} !== 4'b0001) begin n_err++; $display("FAIL adel_side got=%b exp=0001", {done32, req32, ades32, ll32}); end
      tick();
      @(negedge clk);
      n_vec++; if ({adel32, req32, stall32} !== 3'b000) begin n_err++; $display("FAIL adel_after got=%b exp=000", {adel32, req32, stall32}); end
      // SC with link bit set goes to the bus and succeeds.
      tick(); ov32 = 1'b1; op = LSU_SC; addr = 32'h200; wdata = 32'h0000_0055;
      tick(); ack32 = 1'b1;
      @(negedge clk);
      n_vec++; if ({req32, we32, sel32, ll32} !== 7'b1111111) begin n_err++; $display("FAIL sc_bus got=%b exp=1111111", {req32, we32, sel32, ll32}); end
      n_vec++; if (bw32 !== 32'h0000_0055) begin n_err++; $display("FAIL sc_wdata got=%h exp=00000055", bw32); end
      tick(); ack32 = 1'b0; ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if ({done32, rd32} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL sc_ok got=%h exp=100000001", {done32, rd32}); end
      n_vec++; if (ll32 !== 1'b0) begin n_err++; $display("FAIL sc_bit_clr got=%b exp=0", ll32); end
      // Repeated SC fails without a bus cycle.
      tick(); ov32 = 1'b1;
      @(negedge clk);
      n_vec++; if (stall32 !== 1'b1) begin n_err++; $display("FAIL sc2_stall got=%b exp=1", stall32); end
      tick(); ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if ({req32, done32, rd32} !== {1'b0, 1'b1, 32'd0}) begin n_err++; $display("FAIL sc2_fail got=%h exp=%h", {req32, done32, rd32}, {1'b0, 1'b1, 32'd0}); end
   endtask

   task automatic test_timeout();
      tick(); ov32 = 1'b1; op = LSU_LW; addr = 32'h300;
      for (int c = 1; c <= 8; c++) begin
         tick();
         @(negedge clk);
         n_vec++; if ({req32, be32} !== 2'b10) begin n_err++; $display("FAIL to_bus_c%0d got=%b exp=10", c, {req32, be32}); end
      end
      tick(); ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if ({be32, done32, req32, stall32} !== 4'b1000) begin n_err++; $display("FAIL to_err got=%b exp=1000", {be32, done32, req32, stall32}); end
      tick();
      @(negedge clk);
      n_vec++; if (be32 !== 1'b0) begin n_err++; $display("FAIL to_pulse_end got=%b exp=0", be32); end
   endtask

   task automatic test_bus_err();
      tick(); ov32 = 1'b1; op = LSU_LW; addr = 32'h300;
      tick();
      @(negedge clk);
      n_vec++; if (req32 !== 1'b1) begin n_err++; $display("FAIL be_req got=%b exp=1", req32); end
      tick(); err32 = 1'b1;
      @(negedge clk);
      n_vec++; if (be32 !== 1'b0) begin n_err++; $display("FAIL be_early got=%b exp=0", be32); end
      tick(); err32 = 1'b0; ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if ({be32, done32, req32} !== 3'b100) begin n_err++; $display("FAIL be_pulse got=%b exp=100", {be32, done32, req32}); end
   endtask

   task automatic test_flush();
      tick(); ov32 = 1'b1; op = LSU_LW; addr = 32'h300;
      tick(); flush = 1'b1;
      tick(); flush = 1'b0; ack32 = 1'b1; rdi32 = 32'h1111_2222;
      tick(); ack32 = 1'b0; ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if ({done32, be32} !== 2'b00) begin n_err++; $display("FAIL flush_bus got=%b exp=00", {done32, be32}); end
      tick(); ov32 = 1'b1; flush = 1'b1; addr = 32'h304;
      @(negedge clk);
      n_vec++; if (stall32 !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall got=%b exp=0", stall32); end
      tick(); ov32 = 1'b0; flush = 1'b0;
      @(negedge clk);
      n_vec++; if (req32 !== 1'b0) begin n_err++; $display("FAIL flush_idle_req got=%b exp=0", req32); end
   endtask

   task automatic test_llclr();
      tick(); ov32 = 1'b1; op = LSU_LL; addr = 32'h200;
      tick(); ack32 = 1'b1;
      tick(); ack32 = 1'b0; ov32 = 1'b0;
      tick(); llclr = 1'b1;
      tick(); llclr = 1'b0;
      @(negedge clk);
      n_vec++; if (ll32 !== 1'b0) begin n_err++; $display("FAIL llclr_idle got=%b exp=0", ll32); end
      tick(); ov32 = 1'b1; op = LSU_LL;
      tick(); ack32 = 1'b1; llclr = 1'b1;
      tick(); ack32 = 1'b0; llclr = 1'b0; ov32 = 1'b0;
      @(negedge clk);
      n_vec++; if ({done32, ll32} !== 2'b10) begin n_err++; $display("FAIL llclr_wins got=%b exp=10", {done32, ll32}); end
   endtask

   task automatic test_dw64();
      tick(); ov64 = 1'b1; op = LSU_LH; addr = 32'h106;
      @(negedge clk);
      n_vec++; if (stall64 !== 1'b1) begin n_err++; $display("FAIL lh64_stall got=%b exp=1", stall64); end
      tick(); ack64 = 1'b1; rdi64 = 64'h0123_4567_89AB_8001;
      @(negedge clk);
      n_vec++; if (sel64 !== 8'h03) begin n_err++; $display("FAIL lh64_sel got=%h exp=03", sel64); end
      n_vec++; if (ba64 !== 32'h100) begin n_err++; $display("FAIL lh64_addr got=%h exp=100", ba64); end
      tick(); ack64 = 1'b0; ov64 = 1'b0;
      @(negedge clk);
      n_vec++; if ({done64, rd64} !== {1'b1, 32'hFFFF_8001}) begin n_err++; $display("FAIL lh64_rdata got=%h exp=1ffff8001", {done64, rd64}); end
      // Reset while a transaction is on the bus.
      tick(); ov64 = 1'b1; op = LSU_LW; addr = 32'h104;
      tick();
      @(negedge clk);
      n_vec++; if ({req64, sel64} !== {1'b1, 8'h0F}) begin n_err++; $display("FAIL rst64_bus got=%h exp=10f", {req64, sel64}); end
      rst = 1'b1;
      tick(); rst = 1'b0; ov64 = 1'b0;
      @(negedge clk);
      n_vec++; if (req64 !== 1'b0) begin n_err++; $display("FAIL rst64_req got=%b exp=0", req64); end
      n_vec++; if ({stall64, done64, rd64, adel64, ades64, be64, ll64, sel64, we64, ba64, bw64} !== '0) begin n_err++; $display("FAIL rst64_outs got=%h exp=0", {stall64, done64, rd64, adel64, ades64, be64, ll64, sel64, we64, ba64, bw64}); end
   endtask

   initial begin
      rst = 1'b1; ov32 = 1'b0; ov64 = 1'b0; flush = 1'b0; llclr = 1'b0;
      op = LSU_NOP; addr = '0; wdata = '0;
      ack32 = 1'b0; err32 = 1'b0; rdi32 = '0;
      ack64 = 1'b0; err64 = 1'b0; rdi64 = '0;
      test_reset();
      test_load_byte();
      test_store_half();
      test_ll_sc_misaligned();
      test_timeout();
      test_bus_err();
      test_flush();
      test_llclr();
      test_dw64();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Multi-cycle load/store unit that replaces the purely combinational memory stage.
- Takes one memory op from the EX/MEM register and runs a req/ack transaction on the data bus. Stalls the pipeline until the transaction ends, then returns aligned, extended load data.
- Owns the LLbit for LL/SC, detects misaligned addresses, and reports bus errors and timeouts.
- Parametrised in data-bus width and timeout; big-endian byte lanes (byte offset 0 is the most significant lane).

Parameters:
- AW, 32, address width.
- DW, 32, data-bus width (32 or 64); SW = DW/8 byte selects.
- TIMEOUT, 255, cycles to wait for bus_ack_i before flagging a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- op_valid_i  in  1  a memory op is present; held stable while stall_req_o is high.
- op_i  in  4  LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC (LSU_* codes); other codes are ignored.
- addr_i  in  AW  effective byte address.
- wdata_i  in  32  store data (reg2).
- flush_i  in  1  pipeline flush (exception or eret).
- llclr_i  in  1  clear LLbit (eret).
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  write enable.
- bus_addr_o  out  AW  address, aligned to the DW boundary.
- bus_sel_o  out  SW  byte-lane enables.
- bus_wdata_o  out  DW  store data replicated across lanes.
- bus_ack_i  in  1  transaction complete; bus_rdata_i is valid in the same cycle.
- bus_rdata_i  in  DW  read data.
- bus_err_i  in  1  bus error, sampled only while bus_req_o is high.
- stall_req_o  out  1  stall request to the pipeline controller.
- done_o  out  1  one-cycle pulse: result is valid.
- rdata_o  out  32  load result, or SC status (1 = success, 0 = fail).
- exc_adel_o / exc_ades_o  out  1  misaligned load / misaligned store, one-cycle pulse.
- exc_buserr_o  out  1  bus error or timeout, one-cycle pulse.
- llbit_o  out  1  current LLbit.

Behaviour:
- Reset: state IDLE and LLbit = 0. Every output is 0, including bus_req_o, stall_req_o, done_o, rdata_o, the exception flags and the timeout counter.
- States: IDLE, BUS, DONE.
- IDLE, no new op (op_valid_i low, or op_i not a memory op):
  - Stay in IDLE; stall_req_o = 0.
- IDLE, accepting an op (op_valid_i high, valid memory op, flush_i low):
  - Alignment check: halfword ops need addr[0] = 0; LW, SW, LL and SC need addr[1:0] = 0.
  - Misaligned: no bus cycle; pulse exc_adel_o or exc_ades_o in the next cycle; go to DONE with done_o suppressed.
  - SC with LLbit = 0: no bus cycle; go to DONE with rdata_o = 0.
  - Otherwise: register address, lanes, we and data, then go to BUS. bus_req_o rises the next cycle.
  - stall_req_o is driven combinationally high during the accept cycle.
- BUS:
  - bus_req_o = 1 and stall_req_o = 1; all bus outputs are held constant.
  - Timeout counter increments every cycle.
  - bus_ack_i: capture and extract data, go to DONE.
  - bus_err_i, or counter reaching TIMEOUT: pulse exc_buserr_o, go to DONE with done_o suppressed.
  - Minimum load latency: accept (cycle 0), BUS (cycle 1, ack), DONE (cycle 2, done_o).
- DONE:
  - done_o = 1 unless suppressed; stall_req_o = 0; return to IDLE next cycle.
  - The pipeline advances in this cycle, so a back-to-back op is accepted in the following IDLE cycle.
- Lane mapping:
  - lane index = addr[log2(SW)-1:0]; byte k maps to bus_sel_o[SW-1-k].
  - Halfwords use two adjacent lanes; words use four lanes at (addr & ~3).
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Store data: byte ops replicate wdata_i[7:0] SW times, halfword ops replicate [15:0], word ops replicate [31:0] DW/32 times.
- LLbit:
  - LL sets LLbit to 1 when its ack arrives.
  - A successful SC clears LLbit when its ack arrives; rdata_o = 1.
  - llclr_i clears LLbit in any state. If llclr_i coincides with an LL ack, the clear wins.
- flush_i:
  - In IDLE: the op is dropped.
  - In BUS: the transaction still runs to ack, error or timeout, because the bus cannot be aborted. done_o, the exception flags and the LLbit update are then suppressed.
- rst mid-transaction: immediate return to IDLE; bus_req_o is low in the cycle after rst. The slave must tolerate the abandoned request.

Decomposition:
- Package lsu_pkg: LSU_* op codes, the state enum, and the ADEL/ADES/BUSERR cause constants.
- Sub-module lsu_lane: purely combinational. Computes sel from (op, offset), replicates store data, and extracts/extends load data. It is instantiated once and is parametrised by DW.

Test Plan:
- DW=32, mem[0x100] = 0x8899AABB, LB at 0x101 with ack one cycle after req → bus_sel_o = 0100, done_o in cycle 2, rdata_o = 0xFFFFFF99; LBU at the same address → 0x00000099.
- SH of wdata 0x1234ABCD at 0x102 → bus_wdata_o = 0xABCDABCD, bus_sel_o = 0011, bus_we_o = 1; stall_req_o high for exactly the accept and BUS cycles.
- LW at 0x103 → exc_adel_o pulse, bus_req_o never high, done_o = 0, LLbit unchanged.
- LL at 0x200 then SC at 0x200 → SC rdata_o = 1, LLbit 1 then 0; repeated SC → no bus cycle, rdata_o = 0.
- Slave never acks, TIMEOUT=8 → exc_buserr_o pulse 9 cycles after accept, then IDLE; a separate case asserting bus_err_i in the 2nd BUS cycle gives the same response.
- DW=64, LH at 0x106 with rdata 0x..._8001 in the low halfword → bus_sel_o = 0x03, rdata_o = 0xFFFF8001; rst asserted while in BUS → bus_req_o = 0 next cycle and all outputs 0.
